// File: rtl/serial_bit_source.sv
// serial_bit_source
// Parallel-to-serial source feeding the serial pattern-detector stage.
// Words arrive over a valid/ready handshake and leave MSB first, one bit
// per clock, on ser_out. A single holding register lets the next word queue
// behind the active frame, so back-to-back frames stream without a gap.
//
// Optional feature: define SERIAL_BIT_SOURCE_PARITY_EN to append one
// even-parity bit (XOR of the word) after each frame's LSB. Without the
// macro the parity state and its logic are not built.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no frame active, ser_out parked at IDLE_BIT
// ST_SHIFT | data bits on the line, bcnt_q = index of the bit being sent
// ST_PAR   | parity bit on the line (only with SERIAL_BIT_SOURCE_PARITY_EN)

module serial_bit_source #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int             BW        = $clog2(WIDTH + 1);
    localparam logic [BW-1:0]  BCNT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;

    logic             accept;
    logic             frame_end;
    logic             load_en;
    logic [WIDTH-1:0] load_word;

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    logic             par_q, par_d;
`endif

    // Ready depends only on registered state so upstream sees no comb loop.
    assign din_ready = !hold_full_q;
    assign accept    = din_valid && !hold_full_q;

    // Next-state: shift/count, park accepted words in the hold register
    // mid-frame, and on the final edge of a frame chain the next word in.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load_en     = 1'b0;
        load_word   = din;
        frame_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Idle accept bypasses the hold register entirely.
                if (accept) begin
                    load_en = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bcnt_q != BCNT_LAST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    bcnt_d  = bcnt_q + BW'(1);
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else begin
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                    // LSB edge is not the frame end: the parity bit follows.
                    state_d = ST_PAR;
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            ST_PAR: begin
                frame_end = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A held word always wins; ready is low then, so no accept competes.
        if (frame_end) begin
            if (hold_full_q) begin
                load_en     = 1'b1;
                load_word   = hold_q;
                hold_full_d = 1'b0;
            end else if (accept) begin
                load_en = 1'b1;
            end else begin
                state_d = ST_IDLE;
                bcnt_d  = '0;
            end
        end

        if (load_en) begin
            shreg_d = load_word;
            bcnt_d  = '0;
            state_d = ST_SHIFT;
        end
    end

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    // Parity is captured with the word, since the shifter loses it bit by bit.
    always_comb begin
        par_d = par_q;
        if (load_en) begin
            par_d = ^load_word;
        end
    end
`endif

    // State registers; reset discards any partial frame and any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bcnt_q      <= '0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bcnt_q      <= bcnt_d;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Output decode straight from registered state; no input feeds through.
    always_comb begin
        ser_valid   = (state_q != ST_IDLE);
        frame_start = (state_q == ST_SHIFT) && (bcnt_q == '0);
        busy        = (state_q != ST_IDLE) || hold_full_q;
        case (state_q)
            ST_SHIFT: ser_out = shreg_q[WIDTH-1];
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            ST_PAR:   ser_out = par_q;
`endif
            default:  ser_out = IDLE_BIT;
        endcase
    end

endmodule

// File: tb/tb_serial_bit_source.sv
module tb_serial_bit_source;

    localparam int W = 8;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    localparam int FL  = W + 1;
    localparam int FL4 = 5;
`else
    localparam int FL  = W;
    localparam int FL4 = 4;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready, ser_out, ser_valid, frame_start, busy;

    logic [3:0]   din4 = '0;
    logic         v4 = 1'b0;
    logic         rdy4, out4, sv4, fs4, busy4;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .frame_start(frame_start), .busy(busy)
    );

    serial_bit_source #(.WIDTH(4), .IDLE_BIT(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(v4),
        .din_ready(rdy4), .ser_out(out4), .ser_valid(sv4),
        .frame_start(fs4), .busy(busy4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bits still to appear on the line, plus the hold slot.
    logic         mq[$];
    logic         m_held;
    logic [W-1:0] m_hold;

    function automatic void m_load(input logic [W-1:0] w);
        mq.delete();
        for (int i = W - 1; i >= 0; i--) mq.push_back(w[i]);
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        mq.push_back(^w);
`endif
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_held = 1'b0;
        m_hold = '0;
    endfunction

    function automatic void m_step(input logic v, input logic [W-1:0] d);
        logic acc;
        acc = v && !m_held;
        if (mq.size() == 0) begin
            if (acc) m_load(d);
        end else begin
            mq.delete(0);
            if (mq.size() == 0) begin
                if (m_held) begin
                    m_load(m_hold);
                    m_held = 1'b0;
                end else if (acc) begin
                    m_load(d);
                end
            end else if (acc) begin
                m_held = 1'b1;
                m_hold = d;
            end
        end
    endfunction

    task automatic m_check();
        logic ev;
        ev = (mq.size() != 0);
        chk("ser_valid", ser_valid, ev);
        chk("ser_out", ser_out, ev ? mq[0] : 1'b0);
        chk("frame_start", frame_start, mq.size() == FL);
        chk("din_ready", din_ready, !m_held);
        chk("busy", busy, ev || m_held);
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, output logic acc);
        @(negedge clk);
        m_check();
        din_valid = v;
        din       = d;
        acc       = v && din_ready;
        m_step(v, d);
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         eo, esv, efs, erdy, ebusy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [W-1:0] d, input logic eo,
                                input logic esv, input logic efs, input logic erdy,
                                input logic ebusy);
        vec_t r;
        r.v = v; r.d = d; r.eo = eo; r.esv = esv; r.efs = efs; r.erdy = erdy; r.ebusy = ebusy;
        tbl.push_back(r);
    endfunction

    logic [W-1:0] words [3];

    initial begin
        logic       a;
        logic [3:0] hist;
        int         nvb, det, idx, nacc, nv, firstv, lastv, ready_low, nfs;
        int         fsq[$];
        logic       exp4[$];

        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        m_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ser_out", ser_out, 1'b0);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_din_ready", din_ready, 1'b1);
        chk("rst_w4_ser_out", out4, 1'b1);
        rst_n = 1'b1;

        // Single 8'hB0 frame, din wiggling while not valid
        add(1, 8'hB0, 0, 0, 0, 1, 0);
        add(0, 8'h4F, 1, 1, 1, 1, 1);
        add(0, 8'hFF, 0, 1, 0, 1, 1);
        add(0, 8'h00, 1, 1, 0, 1, 1);
        add(0, 8'h12, 1, 1, 0, 1, 1);
        add(0, 8'h34, 0, 1, 0, 1, 1);
        add(0, 8'h56, 0, 1, 0, 1, 1);
        add(0, 8'h78, 0, 1, 0, 1, 1);
        add(0, 8'h9A, 0, 1, 0, 1, 1);
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        add(0, 8'hBC, 1, 1, 0, 1, 1);
`endif
        add(0, 8'hDE, 0, 0, 0, 1, 0);
        add(0, 8'hF0, 0, 0, 0, 1, 0);
        hist = '0; nvb = 0; det = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            chk("tbl_ser_out", ser_out, tbl[i].eo);
            chk("tbl_ser_valid", ser_valid, tbl[i].esv);
            chk("tbl_frame_start", frame_start, tbl[i].efs);
            chk("tbl_din_ready", din_ready, tbl[i].erdy);
            chk("tbl_busy", busy, tbl[i].ebusy);
            if (ser_valid) begin
                hist = {hist[2:0], ser_out};
                nvb++;
                if (nvb >= 4 && hist == 4'b1011) det++;
            end
            din_valid = tbl[i].v;
            din       = tbl[i].d;
        end
        chk("detect_1011_count", det, 1);

        // Streaming three words with valid held high
        idx = 0; nacc = 0; nv = 0; firstv = -1; lastv = -1; ready_low = 0;
        for (int c = 0; c < 3 * FL + 10; c++) begin
            logic v;
            v = (idx < 3);
            cycle(v, v ? words[idx % 3] : '0, a);
            if (ser_valid) begin
                nv++;
                if (firstv < 0) firstv = c;
                lastv = c;
            end
            if (!din_ready) ready_low = 1;
            if (a) begin
                idx++;
                nacc++;
            end
        end
        chk("stream_accepts", nacc, 3);
        chk("stream_bits", nv, 3 * FL);
        chk("stream_span", lastv - firstv + 1, 3 * FL);
        chk("stream_ready_low_seen", ready_low, 1);

        // Word presented exactly on the last-bit cycle, hold empty
        for (int c = 0; c <= 3 * FL; c++) begin
            logic v;
            v = (c == 0) || (c == FL);
            cycle(v, (c == 0) ? 8'hC3 : 8'h5A, a);
            if (frame_start) fsq.push_back(c);
            if (v) chk("bypass_accept", a, 1'b1);
        end
        chk("bypass_pulses", fsq.size(), 2);
        if (fsq.size() >= 2) chk("bypass_spacing", fsq[1] - fsq[0], FL);

        // Reset mid-frame at bit 3 of 8'hF0 with 8'h55 held
        cycle(1, 8'hF0, a);
        cycle(1, 8'h55, a);
        chk("rst_seq_hold_accept", a, 1'b1);
        cycle(0, 8'h00, a);
        cycle(0, 8'h00, a);
        @(negedge clk);
        m_check();
        chk("pre_rst_ready", din_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ser_out", ser_out, 1'b0);
        chk("mid_rst_ser_valid", ser_valid, 1'b0);
        chk("mid_rst_frame_start", frame_start, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_din_ready", din_ready, 1'b1);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 8'h0F, a);
        nfs = 0; nv = 0;
        for (int c = 0; c < FL + 4; c++) begin
            cycle(0, 8'h55, a);
            if (frame_start) nfs++;
            if (ser_valid) nv++;
        end
        chk("post_rst_frames", nfs, 1);
        chk("post_rst_bits", nv, FL);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 99) < 60, W'($urandom), a);
        end
        for (int c = 0; c < 3 * FL; c++) begin
            cycle(0, W'($urandom), a);
        end

        // WIDTH=4, IDLE_BIT=1 instance
        exp4.push_back(1'b1); exp4.push_back(1'b0); exp4.push_back(1'b0); exp4.push_back(1'b1);
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        exp4.push_back(1'b0);
`endif
        @(negedge clk);
        chk("w4_idle_out", out4, 1'b1);
        chk("w4_idle_valid", sv4, 1'b0);
        chk("w4_idle_ready", rdy4, 1'b1);
        v4 = 1'b1; din4 = 4'h9;
        for (int i = 0; i < FL4; i++) begin
            @(negedge clk);
            v4 = 1'b0; din4 = 4'h6;
            chk("w4_bit", out4, exp4[i]);
            chk("w4_valid", sv4, 1'b1);
            chk("w4_frame_start", fs4, i == 0);
            chk("w4_busy", busy4, 1'b1);
        end
        @(negedge clk);
        chk("w4_end_out", out4, 1'b1);
        chk("w4_end_valid", sv4, 1'b0);
        chk("w4_end_busy", busy4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
